// File: rtl/regfile_write_arbiter.sv
// Register-file write port arbiter: clears all 32 registers after reset, then arbitrates
// writeback vs. debug writes, with a starvation counter that bounds debug wait time.
module regfile_write_arbiter #(
  parameter int DBG_MAX_WAIT   = 4,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        wb_req,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  output logic        wb_ack,
  input  logic        dbg_req,
  input  logic [4:0]  dbg_addr,
  input  logic [31:0] dbg_data,
  output logic        dbg_ack,
  output logic        rf_write,
  output logic [4:0]  rf_write_address,
  output logic [31:0] rf_write_data,
  output logic        clear_busy
);

  localparam int SW = (DBG_MAX_WAIT < 1) ? 1 : $clog2(DBG_MAX_WAIT + 1);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t        state, state_next;
  logic [4:0]    clr_cnt;
  logic [SW-1:0] starve_cnt, starve_next;
  logic          starved;

  always_comb begin
    wb_ack      = 1'b0;
    dbg_ack     = 1'b0;
    state_next  = state;
    starve_next = '0;
    starved     = (starve_cnt == SW'(DBG_MAX_WAIT));
    if (!reset && state == RUN) begin
      dbg_ack = dbg_req && (!wb_req || starved);
      wb_ack  = wb_req && !dbg_ack;
    end
    if (state == CLEAR && clr_cnt == 5'd31)
      state_next = RUN;
    // Saturates at DBG_MAX_WAIT; reaching it forces the next debug grant.
    if (state == RUN && dbg_req && !dbg_ack)
      starve_next = starved ? starve_cnt : starve_cnt + SW'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state            <= (CLEAR_ON_RESET != 0) ? CLEAR : RUN;
      clear_busy       <= (CLEAR_ON_RESET != 0);
      clr_cnt          <= '0;
      starve_cnt       <= '0;
      rf_write         <= 1'b0;
      rf_write_address <= '0;
      rf_write_data    <= '0;
    end else begin
      state      <= state_next;
      clear_busy <= (state_next == CLEAR);
      clr_cnt    <= (state == CLEAR) ? clr_cnt + 5'd1 : '0;
      starve_cnt <= starve_next;
      if (state == CLEAR) begin
        rf_write         <= 1'b1;
        rf_write_address <= clr_cnt;
        rf_write_data    <= '0;
      end else if (wb_ack) begin
        // x0 is hardwired zero: grant and ack, but suppress the write.
        rf_write         <= (wb_addr != 5'd0);
        rf_write_address <= wb_addr;
        rf_write_data    <= wb_data;
      end else if (dbg_ack) begin
        rf_write         <= (dbg_addr != 5'd0);
        rf_write_address <= dbg_addr;
        rf_write_data    <= dbg_data;
      end else begin
        rf_write <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: clear sequence, priority, starvation,
// x0 suppression, reset mid-clear, and the no-clear variant.
module tb_regfile_write_arbiter;

  logic        clock = 1'b0;
  logic        reset, wb_req, dbg_req;
  logic [4:0]  wb_addr, dbg_addr;
  logic [31:0] wb_data, dbg_data;
  logic        wb_ack, dbg_ack, rf_write, clear_busy;
  logic [4:0]  rf_write_address;
  logic [31:0] rf_write_data;

  logic        nc_reset, nc_wb_req, nc_dbg_req;
  logic [4:0]  nc_wb_addr, nc_dbg_addr;
  logic [31:0] nc_wb_data, nc_dbg_data;
  logic        nc_wb_ack, nc_dbg_ack, nc_rf_write, nc_clear_busy;
  logic [4:0]  nc_rf_write_address;
  logic [31:0] nc_rf_write_data;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  regfile_write_arbiter #(.DBG_MAX_WAIT(4), .CLEAR_ON_RESET(1)) dut (
    .clock(clock), .reset(reset),
    .wb_req(wb_req), .wb_addr(wb_addr), .wb_data(wb_data), .wb_ack(wb_ack),
    .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_data(dbg_data), .dbg_ack(dbg_ack),
    .rf_write(rf_write), .rf_write_address(rf_write_address),
    .rf_write_data(rf_write_data), .clear_busy(clear_busy)
  );

  regfile_write_arbiter #(.DBG_MAX_WAIT(4), .CLEAR_ON_RESET(0)) dut_nc (
    .clock(clock), .reset(nc_reset),
    .wb_req(nc_wb_req), .wb_addr(nc_wb_addr), .wb_data(nc_wb_data), .wb_ack(nc_wb_ack),
    .dbg_req(nc_dbg_req), .dbg_addr(nc_dbg_addr), .dbg_data(nc_dbg_data), .dbg_ack(nc_dbg_ack),
    .rf_write(nc_rf_write), .rf_write_address(nc_rf_write_address),
    .rf_write_data(nc_rf_write_data), .clear_busy(nc_clear_busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1; wb_req = 1'b1; wb_addr = 5'd1; wb_data = 32'h1;
    dbg_req = 1'b0; dbg_addr = '0; dbg_data = '0;
    nc_reset = 1'b1; nc_wb_req = 1'b1; nc_wb_addr = 5'd12; nc_wb_data = 32'hCAFE;
    nc_dbg_req = 1'b0; nc_dbg_addr = '0; nc_dbg_data = '0;
    tick();
    tick();
    check("rst_rf_write", 32'(rf_write), 32'd0);
    check("rst_addr", 32'(rf_write_address), 32'd0);
    check("rst_data", rf_write_data, 32'd0);
    check("rst_clear_busy", 32'(clear_busy), 32'd1);
    check("rst_wb_ack", 32'(wb_ack), 32'd0);
    check("nc_rst_wb_ack", 32'(nc_wb_ack), 32'd0);
    check("nc_rst_clear_busy", 32'(nc_clear_busy), 32'd0);

    // No-clear variant: first cycle after reset is already RUN
    nc_reset = 1'b0;
    #1;
    check("nc_clear_busy", 32'(nc_clear_busy), 32'd0);
    check("nc_first_wb_ack", 32'(nc_wb_ack), 32'd1);
    tick();
    nc_wb_req = 1'b0;
    check("nc_rf_write", 32'(nc_rf_write), 32'd1);
    check("nc_rf_addr", 32'(nc_rf_write_address), 32'd12);
    check("nc_rf_data", nc_rf_write_data, 32'hCAFE);

    // Full clear sequence, no requests
    reset = 1'b0; wb_req = 1'b0;
    for (int i = 0; i < 32; i++) begin
      tick();
      check("clr_write", 32'(rf_write), 32'd1);
      check("clr_addr", 32'(rf_write_address), 32'(i));
      check("clr_data", rf_write_data, 32'd0);
      check("clr_busy", 32'(clear_busy), (i < 31) ? 32'd1 : 32'd0);
    end
    tick();
    check("post_clr_write", 32'(rf_write), 32'd0);

    // Writeback write
    wb_req = 1'b1; wb_addr = 5'd5; wb_data = 32'hDEADBEEF;
    #1;
    check("wb_ack", 32'(wb_ack), 32'd1);
    check("wb_dbg_ack", 32'(dbg_ack), 32'd0);
    tick();
    wb_req = 1'b0;
    check("wb_rf_write", 32'(rf_write), 32'd1);
    check("wb_rf_addr", 32'(rf_write_address), 32'd5);
    check("wb_rf_data", rf_write_data, 32'hDEADBEEF);

    // Contention: four writeback grants, then forced debug grant
    wb_req = 1'b1; wb_addr = 5'd3; wb_data = 32'hA;
    dbg_req = 1'b1; dbg_addr = 5'd7; dbg_data = 32'hB;
    for (int c = 0; c < 7; c++) begin
      #1;
      check("arb_wb_ack", 32'(wb_ack), (c == 4) ? 32'd0 : 32'd1);
      check("arb_dbg_ack", 32'(dbg_ack), (c == 4) ? 32'd1 : 32'd0);
      check("arb_one_hot", 32'(wb_ack & dbg_ack), 32'd0);
      tick();
      check("arb_rf_addr", 32'(rf_write_address), (c == 4) ? 32'd7 : 32'd3);
      check("arb_rf_data", rf_write_data, (c == 4) ? 32'hB : 32'hA);
    end
    wb_req = 1'b0; dbg_req = 1'b0;
    tick();

    // Debug write to x0 is acked but not written
    dbg_req = 1'b1; dbg_addr = 5'd0; dbg_data = 32'h1234;
    #1;
    check("x0_dbg_ack", 32'(dbg_ack), 32'd1);
    tick();
    dbg_req = 1'b0;
    check("x0_rf_write", 32'(rf_write), 32'd0);

    dbg_req = 1'b1; dbg_addr = 5'd9; dbg_data = 32'h99;
    #1;
    check("dbg_ack", 32'(dbg_ack), 32'd1);
    tick();
    dbg_req = 1'b0;
    check("dbg_rf_write", 32'(rf_write), 32'd1);
    check("dbg_rf_addr", 32'(rf_write_address), 32'd9);
    check("dbg_rf_data", rf_write_data, 32'h99);

    // Reset mid-clear at address 17, requests pending throughout
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 18; i++) tick();
    check("mid_addr17", 32'(rf_write_address), 32'd17);
    reset = 1'b1;
    wb_req = 1'b1; wb_addr = 5'd4; wb_data = 32'h55;
    dbg_req = 1'b1; dbg_addr = 5'd6; dbg_data = 32'h66;
    tick();
    check("mid_rst_write", 32'(rf_write), 32'd0);
    check("mid_rst_busy", 32'(clear_busy), 32'd1);
    reset = 1'b0;
    for (int i = 0; i < 32; i++) begin
      #1;
      check("mid_wb_ack", 32'(wb_ack), 32'd0);
      check("mid_dbg_ack", 32'(dbg_ack), 32'd0);
      tick();
      check("mid_clr_write", 32'(rf_write), 32'd1);
      check("mid_clr_addr", 32'(rf_write_address), 32'(i));
    end
    #1;
    check("held_wb_ack", 32'(wb_ack), 32'd1);
    check("held_dbg_ack0", 32'(dbg_ack), 32'd0);
    tick();
    wb_req = 1'b0;
    check("held_wb_addr", 32'(rf_write_address), 32'd4);
    check("held_wb_data", rf_write_data, 32'h55);
    #1;
    check("held_dbg_ack", 32'(dbg_ack), 32'd1);
    tick();
    dbg_req = 1'b0;
    check("held_dbg_addr", 32'(rf_write_address), 32'd6);
    check("held_dbg_data", rf_write_data, 32'h66);
    tick();
    check("idle_write", 32'(rf_write), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 SHALL take parameter DBG_MAX_WAIT, default 4: the number of consecutive cycles the debug requester may lose arbitration before it is granted priority.
REQ-002 SHALL take parameter CLEAR_ON_RESET, default 1: when 1, all 32 registers are zeroed after reset.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 Port list (name, direction, width, meaning):
- clock, in, 1: rising-edge clock.
- reset, in, 1: synchronous active-high reset.
- wb_req, in, 1: writeback write request.
- wb_addr, in, 5: writeback target register.
- wb_data, in, 32: writeback write data.
- wb_ack, out, 1: writeback request accepted this cycle.
- dbg_req, in, 1: debug/loader write request.
- dbg_addr, in, 5: debug target register.
- dbg_data, in, 32: debug write data.
- dbg_ack, out, 1: debug request accepted this cycle.
- rf_write, out, 1: register file write enable.
- rf_write_address, out, 5: register file write address.
- rf_write_data, out, 32: register file write data.
- clear_busy, out, 1: clear sequence in progress.

Function
REQ-005 SHALL implement two states, CLEAR and RUN.
- Reset enters CLEAR if CLEAR_ON_RESET=1; otherwise it enters RUN.
REQ-006 In CLEAR, SHALL issue one write per cycle with data 0 to addresses 0,1,...,31 in order, using a 5-bit counter.
- After the address-31 write, SHALL move to RUN.
REQ-007 clear_busy SHALL be registered and high exactly while state is CLEAR.
REQ-008 In CLEAR, wb_ack and dbg_ack SHALL be 0; requests are held, not dropped.
REQ-009 In RUN, acks SHALL be combinational from the request inputs, the state and the starvation counter.
- At most one ack SHALL be high per cycle.
REQ-010 Requester handshake:
- A requester holds req, addr and data stable until it sees ack high.
- The transfer completes in the ack cycle.
- req may drop in the following cycle.
REQ-011 Default priority SHALL be writeback: wb_req=1 gives wb_ack=1.
- dbg_ack=1 only when wb_req=0, or when the starvation counter equals DBG_MAX_WAIT.
REQ-012 Starvation counter:
- Saturating, width clog2(DBG_MAX_WAIT+1).
- Increments each RUN cycle with dbg_req=1 and dbg_ack=0.
- Clears to 0 on dbg_ack or dbg_req=0.
REQ-013 When the counter equals DBG_MAX_WAIT and both requests are high:
- dbg_ack=1 and wb_ack=0 for that one cycle.
- The counter then clears.
REQ-014 Write outputs SHALL be registered, one cycle of latency.
- The edge closing an accepted cycle loads rf_write=1, rf_write_address=addr and rf_write_data=data of the granted requester.
- Otherwise rf_write=0; address and data hold their previous values.
REQ-015 A granted request with addr=0 SHALL be acked but SHALL produce rf_write=0 (x0 stays zero).
- CLEAR writes to address 0 are still issued.
REQ-016 A request asserted in CLEAR is considered on the first RUN cycle under the normal priority rules.

Reset
REQ-017 On any edge with reset=1, regardless of state:
- rf_write=0, rf_write_address=0, rf_write_data=0.
- Starvation counter=0 and clear counter=0.
- clear_busy=CLEAR_ON_RESET; state=CLEAR if CLEAR_ON_RESET=1, else RUN.
REQ-018 Reset during CLEAR SHALL restart the sequence from address 0.
- Reset during RUN SHALL discard any in-flight registered write.
REQ-019 While reset=1, wb_ack and dbg_ack SHALL be 0.

Verification
REQ-020 Reset then release with no requests:
- 32 consecutive cycles of rf_write=1, addresses 0..31, data 0.
- clear_busy low from the edge after address 31.
- rf_write=0 afterwards.
REQ-021 RUN, wb_req with addr=5 and data=0xDEADBEEF:
- wb_ack=1 the same cycle.
- Next cycle: rf_write=1, address 5, data 0xDEADBEEF.
REQ-022 RUN, wb_req and dbg_req held high, DBG_MAX_WAIT=4:
- wb_ack for 4 cycles, then dbg_ack on the 5th cycle, then wb_ack again.
- Never both acks in one cycle.
REQ-023 RUN, dbg_req with addr=0 and data=0x1234:
- dbg_ack=1.
- rf_write stays 0 the next cycle.
REQ-024 Reset asserted at clear address 17, held 1 cycle, released:
- Clear restarts at address 0 and completes 32 writes.
- Requests issued meanwhile see no ack until RUN.
REQ-025 CLEAR_ON_RESET=0, reset release:
- clear_busy=0 immediately.
- A wb_req on the first cycle after reset is acked in that cycle.
